// File: rtl/bridge_driver_pkg.sv
// Shared types and cycle-count helpers for the DRSSTC bridge driver.
package bridge_driver_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, LOCK} state_t;

  // Converts a time in units of 1/div us into clock cycles.
  function automatic int to_cyc(int mhz, int t, int div);
    return mhz * t / div;
  endfunction

  function automatic int dt_cyc(int mhz, int ns);
    int c;
    c = mhz * ns / 1000;
    return (c < 1) ? 1 : c;
  endfunction

  // Width of a counter that must hold the value n.
  function automatic int cnt_w(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bridge_driver_dead_time.sv
// One dead-time channel: tracks drive polarity and blanks both legs after each edge.
module dead_time_ch
  import bridge_driver_pkg::*;
#(
  parameter int DT_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic load_en,
  output logic sig_edge,
  output logic phase_a,
  output logic phase_b
);

  localparam int W = cnt_w(DT_CYC);
  localparam logic [W-1:0] DT_LD = W'(DT_CYC);

  logic         sig_q;
  logic [W-1:0] dt_cnt, dt_nxt;

  assign sig_edge = sig ^ sig_q;

  always_comb begin
    dt_nxt = dt_cnt;
    if (sig_edge || load_en) dt_nxt = DT_LD;
    else if (dt_cnt != '0)   dt_nxt = dt_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q  <= 1'b0;
      dt_cnt <= '0;
    end else begin
      sig_q  <= sig;
      dt_cnt <= dt_nxt;
    end
  end

  // Phases describe the value the gates take after this edge, so the top can register them.
  assign phase_a = (dt_nxt == '0) &  sig;
  assign phase_b = (dt_nxt == '0) & ~sig;

endmodule

// File: rtl/bridge_driver.sv
// Burst FSM for the H-bridge: zero-current turn-off, on-time limit and over-current lockout.
module bridge_driver
  import bridge_driver_pkg::*;
#(
  parameter int CLK_MHZ          = 100,
  parameter int DEAD_TIME_NS     = 100,
  parameter int MAX_ON_US        = 200,
  parameter int DRAIN_TIMEOUT_US = 4,
  parameter int LOCKOUT_US       = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic intr,
  input  logic ocd,
  output logic gate_a,
  output logic gate_b,
  output logic active,
  output logic fault
);

  localparam int DT_CYC   = dt_cyc(CLK_MHZ, DEAD_TIME_NS);
  localparam int MAX_CYC  = to_cyc(CLK_MHZ, MAX_ON_US, 1);
  localparam int DRN_CYC  = to_cyc(CLK_MHZ, DRAIN_TIMEOUT_US, 1);
  localparam int LOCK_CYC = to_cyc(CLK_MHZ, LOCKOUT_US, 1);
  localparam int ON_W     = cnt_w(MAX_CYC);
  localparam int DRN_W    = cnt_w(DRN_CYC);
  localparam int LOCK_W   = cnt_w(LOCK_CYC);
  localparam logic [ON_W-1:0]   ON_LAST = ON_W'(MAX_CYC - 1);
  localparam logic [DRN_W-1:0]  DRN_LD  = DRN_W'(DRN_CYC - 1);
  localparam logic [LOCK_W-1:0] LOCK_LD = LOCK_W'(LOCK_CYC - 1);

  state_t              state, state_nxt;
  logic                intr_q, intr_rise, ocd_lat, lat_nxt;
  logic                load_en, stop, finish, burst_nxt;
  logic                sig_edge, phase_a, phase_b;
  logic [ON_W-1:0]     on_cnt, on_nxt;
  logic [DRN_W-1:0]    drn_cnt, drn_nxt;
  logic [LOCK_W-1:0]   lock_cnt, lock_nxt;

  assign intr_rise = intr & ~intr_q;

  dead_time_ch #(.DT_CYC(DT_CYC)) u_dt (
    .clk(clk), .rst(rst), .sig(sig), .load_en(load_en),
    .sig_edge(sig_edge), .phase_a(phase_a), .phase_b(phase_b)
  );

  always_comb begin
    state_nxt = state;
    on_nxt    = on_cnt;
    drn_nxt   = drn_cnt;
    lock_nxt  = lock_cnt;
    lat_nxt   = ocd_lat;
    load_en   = 1'b0;
    stop      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        lat_nxt = 1'b0;
        if (ocd) begin
          state_nxt = LOCK;
          lock_nxt  = LOCK_LD;
        end else if (intr_rise) begin
          state_nxt = RUN;
          load_en   = 1'b1;
          on_nxt    = '0;
        end
      end
      RUN: begin
        if (on_cnt != ON_LAST) on_nxt = on_cnt + 1'b1;
        if (ocd) lat_nxt = 1'b1;
        stop = ocd | (on_cnt == ON_LAST) | ~intr;
        if (stop && sig_edge) begin
          finish = 1'b1;
        end else if (stop) begin
          state_nxt = DRAIN;
          drn_nxt   = DRN_LD;
        end
      end
      DRAIN: begin
        if (ocd) lat_nxt = 1'b1;
        if (sig_edge || drn_cnt == '0) finish = 1'b1;
        else                           drn_nxt = drn_cnt - 1'b1;
      end
      LOCK: begin
        if (ocd) begin
          lock_nxt = LOCK_LD;
        end else if (lock_cnt == '0) begin
          state_nxt = IDLE;
          lat_nxt   = 1'b0;
        end else begin
          lock_nxt = lock_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Turn-off lands in LOCK if over-current was seen anywhere in this burst.
    if (finish) begin
      if (lat_nxt) begin
        state_nxt = LOCK;
        lock_nxt  = LOCK_LD;
      end else begin
        state_nxt = IDLE;
        lat_nxt   = 1'b0;
      end
    end
  end

  assign burst_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      intr_q   <= 1'b0;
      ocd_lat  <= 1'b0;
      on_cnt   <= '0;
      drn_cnt  <= '0;
      lock_cnt <= '0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      active   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      intr_q   <= intr;
      ocd_lat  <= lat_nxt;
      on_cnt   <= on_nxt;
      drn_cnt  <= drn_nxt;
      lock_cnt <= lock_nxt;
      gate_a   <= burst_nxt & phase_a;
      gate_b   <= burst_nxt & phase_b;
      active   <= burst_nxt;
      fault    <= lat_nxt | (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_bridge_driver.sv
// Randomized scoreboard bench for bridge_driver using a timestamp-based burst model.
module tb_bridge_driver;

  localparam int DT   = 10;
  localparam int MAXC = 200;
  localparam int DRN  = 400;
  localparam int LOCK = 1000;

  logic clk = 1'b0;
  logic rst, sig, intr, ocd;
  logic gate_a, gate_b, active, fault;

  bridge_driver #(
    .CLK_MHZ(100), .DEAD_TIME_NS(100), .MAX_ON_US(2),
    .DRAIN_TIMEOUT_US(4), .LOCKOUT_US(10)
  ) dut (
    .clk(clk), .rst(rst), .sig(sig), .intr(intr), .ocd(ocd),
    .gate_a(gate_a), .gate_b(gate_b), .active(active), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {bit a; bit b; bit act; bit flt;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  // Reference model: burst timing kept as absolute cycle timestamps.
  int cyc, last_edge, burst_start, drain_end, lock_end;
  bit in_burst, draining, locked, latched, prev_s, prev_i;

  task automatic end_burst();
    in_burst = 0;
    draining = 0;
    if (latched) begin
      locked   = 1;
      lock_end = cyc + LOCK;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; last_edge = -1000; burst_start = 0; drain_end = 0; lock_end = 0;
      in_burst = 0; draining = 0; locked = 0; latched = 0; prev_s = 0; prev_i = 0;
      q.delete();
    end else begin
      bit e, r, on;
      exp_t x;
      cyc++;
      e = (sig != prev_s);
      r = intr && !prev_i;
      if (e) last_edge = cyc;
      if (locked) begin
        if (ocd) lock_end = cyc + LOCK;
        else if (cyc >= lock_end) begin
          locked  = 0;
          latched = 0;
        end
      end else if (!in_burst) begin
        if (ocd) begin
          locked   = 1;
          lock_end = cyc + LOCK;
        end else if (r) begin
          in_burst    = 1;
          draining    = 0;
          burst_start = cyc;
          last_edge   = cyc;
        end
      end else begin
        if (ocd) latched = 1;
        if (!draining) begin
          if (ocd || (cyc - burst_start >= MAXC) || !intr) begin
            if (e) end_burst();
            else begin
              draining  = 1;
              drain_end = cyc + DRN;
            end
          end
        end else if (e || cyc >= drain_end) begin
          end_burst();
        end
      end
      on    = in_burst && (cyc - last_edge >= DT);
      x.a   = on && sig;
      x.b   = on && !sig;
      x.act = in_burst;
      x.flt = latched || locked;
      q.push_back(x);
      prev_s = sig;
      prev_i = intr;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (gate_a && gate_b) begin
        n_fail++;
        $display("FAIL overlap at t=%0t: gate_a=1 gate_b=1 required never both", $time);
      end
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        n_chk++;
        if ({gate_a, gate_b, active, fault} !== {x.a, x.b, x.act, x.flt}) begin
          n_fail++;
          $display("FAIL outputs at t=%0t: got a/b/act/flt=%b%b%b%b required %b%b%b%b",
                   $time, gate_a, gate_b, active, fault, x.a, x.b, x.act, x.flt);
        end
      end
    end
  end

  task automatic chk(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  int half = 0, hcnt = 0;
  bit rnd = 0;

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rnd) begin
        if ($urandom_range(19) == 0)   sig  = ~sig;
        if ($urandom_range(149) == 0)  intr = ~intr;
        ocd = ($urandom_range(2999) == 0);
      end else if (half > 0) begin
        hcnt++;
        if (hcnt >= half) begin
          sig  = ~sig;
          hcnt = 0;
        end
      end
    end
  endtask

  initial begin
    bit seen;
    rst = 1; sig = 0; intr = 0; ocd = 0;
    repeat (3) @(negedge clk);
    chk("reset gate_a", gate_a, 1'b0);
    chk("reset gate_b", gate_b, 1'b0);
    chk("reset active", active, 1'b0);
    chk("reset fault", fault, 1'b0);
    rst = 0;

    // square-wave burst, interrupter drops mid half-period
    half = 50; tick(20);
    intr = 1; tick(137);
    intr = 0; tick(100);
    // held interrupter: on-time limit, then no restart
    intr = 1; tick(400);
    intr = 0; tick(20);
    // single-cycle over-current, interrupter rise inside lockout ignored
    intr = 1; tick(60);
    ocd = 1; tick(1); ocd = 0;
    tick(100);
    intr = 0; tick(10);
    intr = 1; tick(20);
    intr = 0; tick(1000);
    // drive frozen after interrupter falls: forced turn-off
    intr = 1; tick(80);
    half = 0; intr = 0; tick(450);
    // edges closer than the dead time
    half = 4; intr = 1; tick(100);
    half = 13; tick(60);
    half = 20; intr = 0; tick(60);

    rnd = 1; tick(6000);
    rnd = 0; intr = 0; ocd = 0; half = 0; tick(1200);

    // async reset with a gate on
    sig = 1; tick(3);
    intr = 1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = gate_a;
    end
    chk("gate_a on before reset", seen, 1'b1);
    #2 rst = 1;
    #1;
    chk("async gate_a", gate_a, 1'b0);
    chk("async gate_b", gate_b, 1'b0);
    chk("async active", active, 1'b0);
    chk("async fault", fault, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 0; intr = 0;
    tick(5);
    chk("post-reset idle active", active, 1'b0);
    chk("post-reset idle gate_a", gate_a, 1'b0);
    half = 25; intr = 1; tick(80);
    intr = 0; tick(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
